// File: rtl/costas_pkg.sv
// Shared constants, state encoding and magnitude helper for the Costas loop sequencer.
package costas_pkg;

   localparam int unsigned IQ_W     = 16;
   localparam int unsigned WIN_N    = 20;
   localparam int unsigned HIT_TH   = 16;
   localparam int unsigned AMP_MIN  = 64;
   localparam int unsigned PASS_N   = 2;
   localparam int unsigned FAIL_N   = 2;
   localparam int unsigned MAX_PULL = 50;

   localparam int unsigned EPOCH_W  = $clog2(WIN_N);
   localparam int unsigned HIT_W    = $clog2(WIN_N + 1);
   localparam int unsigned STRK_W   = $clog2(((PASS_N > FAIL_N) ? PASS_N : FAIL_N) + 1);
   localparam int unsigned WCNT_W   = $clog2(MAX_PULL);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PULLIN       = 2'd1,
      TRACK_WIDE   = 2'd2,
      TRACK_NARROW = 2'd3
   } costas_state_t;

   localparam logic [1:0] GAIN_PULL   = 2'd0;
   localparam logic [1:0] GAIN_WIDE   = 2'd1;
   localparam logic [1:0] GAIN_NARROW = 2'd2;

   // |x| with the most negative code clamped to the most positive one
   function automatic logic [IQ_W-1:0] abs_sat(input logic signed [IQ_W-1:0] x);
      if (x[IQ_W-1] && (x[IQ_W-2:0] == '0))
         return {1'b0, {(IQ_W-1){1'b1}}};
      else if (x[IQ_W-1])
         return IQ_W'(-x);
      else
         return x;
   endfunction

endpackage

// File: rtl/costas_lock_det.sv
// Phase-lock detector: per-epoch hit test and fixed-window pass/fail decision.
module costas_lock_det
   import costas_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   epoch_valid,
   input  logic signed [IQ_W-1:0] ip,
   input  logic signed [IQ_W-1:0] qp,
   output logic                   win_pass,
   output logic                   win_fail
);

   logic               v1;
   logic [IQ_W-1:0]    a_i;
   logic [IQ_W-1:0]    a_q;
   logic [EPOCH_W-1:0] epoch_cnt;
   logic [HIT_W-1:0]   hit_cnt;
   logic               hit_c;
   logic [HIT_W-1:0]   hit_sum_c;

   // one extra bit so 2*|Q| cannot wrap
   assign hit_c     = ({1'b0, a_i} > {a_q, 1'b0}) && (a_i >= IQ_W'(AMP_MIN));
   assign hit_sum_c = hit_cnt + HIT_W'(hit_c);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         v1        <= 1'b0;
         a_i       <= '0;
         a_q       <= '0;
         epoch_cnt <= '0;
         hit_cnt   <= '0;
         win_pass  <= 1'b0;
         win_fail  <= 1'b0;
      end else begin
         v1       <= epoch_valid;
         win_pass <= 1'b0;
         win_fail <= 1'b0;
         if (epoch_valid) begin
            a_i <= abs_sat(ip);
            a_q <= abs_sat(qp);
         end
         if (v1) begin
            if (epoch_cnt == EPOCH_W'(WIN_N - 1)) begin
               win_pass  <= (hit_sum_c >= HIT_W'(HIT_TH));
               win_fail  <= (hit_sum_c <  HIT_W'(HIT_TH));
               epoch_cnt <= '0;
               hit_cnt   <= '0;
            end else begin
               epoch_cnt <= epoch_cnt + EPOCH_W'(1);
               hit_cnt   <= hit_sum_c;
            end
         end
      end
   end

endmodule

// File: rtl/costas_loop_ctrl.sv
// Costas loop sequencer: pull-in/track state machine, gain selection and filter strobes.
module costas_loop_ctrl
   import costas_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   epoch_valid,
   input  logic signed [IQ_W-1:0] ip,
   input  logic signed [IQ_W-1:0] qp,
   output logic                   filt_update,
   output logic                   filt_clear,
   output logic [1:0]             gain_sel,
   output logic                   lock,
   output logic                   pull_timeout,
   output logic [1:0]             state
);

   costas_state_t      cur;
   logic [STRK_W-1:0]  pass_cnt;
   logic [STRK_W-1:0]  fail_cnt;
   logic [WCNT_W-1:0]  win_cnt;
   logic               win_pass;
   logic               win_fail;
   logic               accept_c;
   logic               det_clr_c;
   logic               win_done_c;
   logic               go_pull_c;
   logic               lost_c;
   logic               pull_exit_c;
   logic               timeout_c;
   logic               clear_c;

   assign accept_c    = epoch_valid && enable && (cur != IDLE);
   assign det_clr_c   = !enable || (cur == IDLE);
   assign win_done_c  = win_pass || win_fail;
   assign go_pull_c   = (cur == IDLE) && enable;
   assign lost_c      = ((cur == TRACK_WIDE) || (cur == TRACK_NARROW)) && win_fail &&
                        (fail_cnt == STRK_W'(FAIL_N - 1));
   assign pull_exit_c = (cur == PULLIN) && win_pass && (pass_cnt == STRK_W'(PASS_N - 1));
   assign timeout_c   = (cur == PULLIN) && win_done_c && !pull_exit_c &&
                        (win_cnt == WCNT_W'(MAX_PULL - 1));
   assign clear_c     = enable && (go_pull_c || lost_c || timeout_c);
   assign state       = cur;

   costas_lock_det u_lock_det (
      .clk         (clk),
      .rst         (rst),
      .clr         (det_clr_c),
      .epoch_valid (accept_c),
      .ip          (ip),
      .qp          (qp),
      .win_pass    (win_pass),
      .win_fail    (win_fail)
   );

   // a clear strobe takes precedence over an update landing in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         cur          <= IDLE;
         gain_sel     <= GAIN_PULL;
         lock         <= 1'b0;
         filt_update  <= 1'b0;
         filt_clear   <= 1'b0;
         pull_timeout <= 1'b0;
         pass_cnt     <= '0;
         fail_cnt     <= '0;
         win_cnt      <= '0;
      end else begin
         filt_clear   <= clear_c;
         filt_update  <= accept_c && !clear_c;
         pull_timeout <= enable && timeout_c;
         if (!enable) begin
            cur      <= IDLE;
            gain_sel <= GAIN_PULL;
            lock     <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            win_cnt  <= '0;
         end else begin
            case (cur)
               IDLE: begin
                  cur      <= PULLIN;
                  gain_sel <= GAIN_PULL;
                  lock     <= 1'b0;
                  pass_cnt <= '0;
                  fail_cnt <= '0;
                  win_cnt  <= '0;
               end
               PULLIN: begin
                  if (pull_exit_c) begin
                     cur      <= TRACK_WIDE;
                     gain_sel <= GAIN_WIDE;
                     lock     <= 1'b1;
                     pass_cnt <= '0;
                     fail_cnt <= '0;
                     win_cnt  <= '0;
                  end else if (timeout_c) begin
                     pass_cnt <= '0;
                     fail_cnt <= '0;
                     win_cnt  <= '0;
                  end else if (win_done_c) begin
                     win_cnt  <= win_cnt + WCNT_W'(1);
                     pass_cnt <= win_pass ? pass_cnt + STRK_W'(1) : '0;
                  end
               end
               TRACK_WIDE, TRACK_NARROW: begin
                  if (lost_c) begin
                     cur      <= PULLIN;
                     gain_sel <= GAIN_PULL;
                     lock     <= 1'b0;
                     pass_cnt <= '0;
                     fail_cnt <= '0;
                     win_cnt  <= '0;
                  end else if (win_fail) begin
                     fail_cnt <= fail_cnt + STRK_W'(1);
                  end else if (win_pass && (cur == TRACK_WIDE)) begin
                     cur      <= TRACK_NARROW;
                     gain_sel <= GAIN_NARROW;
                     pass_cnt <= '0;
                     fail_cnt <= '0;
                  end else if (win_pass) begin
                     fail_cnt <= '0;
                  end
               end
               default: begin
                  cur      <= IDLE;
                  gain_sel <= GAIN_PULL;
                  lock     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_costas_loop_ctrl.sv
// Directed bench for costas_loop_ctrl: lock acquisition, loss, hit thresholds, timeout, enable drop.
module tb_costas_loop_ctrl;

   localparam int unsigned IQ_W = 16;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   enable;
   logic                   epoch_valid;
   logic signed [IQ_W-1:0] ip;
   logic signed [IQ_W-1:0] qp;
   logic                   filt_update;
   logic                   filt_clear;
   logic [1:0]             gain_sel;
   logic                   lock;
   logic                   pull_timeout;
   logic [1:0]             state;

   int n_run   = 0;
   int n_fail  = 0;
   int to_seen = 0;
   int to_base = 0;

   always #5 clk = ~clk;

   costas_loop_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .epoch_valid  (epoch_valid),
      .ip           (ip),
      .qp           (qp),
      .filt_update  (filt_update),
      .filt_clear   (filt_clear),
      .gain_sel     (gain_sel),
      .lock         (lock),
      .pull_timeout (pull_timeout),
      .state        (state)
   );

   always @(negedge clk) begin
      if (pull_timeout === 1'b1) to_seen <= to_seen + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // back-to-back epochs, one per clock
   task automatic epochs(input int n, input logic signed [IQ_W-1:0] i_v, input logic signed [IQ_W-1:0] q_v);
      for (int k = 0; k < n; k++) begin
         epoch_valid = 1'b1;
         ip          = i_v;
         qp          = q_v;
         step();
      end
      epoch_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; enable = 1'b0; epoch_valid = 1'b0; ip = '0; qp = '0;
      step(); step();
      check("rst_state",   32'(state),        0);
      check("rst_gain",    32'(gain_sel),     0);
      check("rst_lock",    32'(lock),         0);
      check("rst_update",  32'(filt_update),  0);
      check("rst_clear",   32'(filt_clear),   0);
      check("rst_timeout", 32'(pull_timeout), 0);
      rst = 1'b0;
      step();
      check("idle_hold", 32'(state), 0);

      // enable with a coincident epoch that must be ignored
      enable = 1'b1; epoch_valid = 1'b1; ip = 16'sd1000; qp = 16'sd100;
      step();
      epoch_valid = 1'b0;
      check("enter_pullin",  32'(state),       1);
      check("enter_clear",   32'(filt_clear),  1);
      check("idle_epoch_ign", 32'(filt_update), 0);
      step();
      check("clear_one_cycle", 32'(filt_clear), 0);

      // two passing windows -> TRACK_WIDE
      epochs(40, 16'sd1000, 16'sd100);
      check("update_strobe", 32'(filt_update), 1);
      step();
      check("pullin_at_t2", 32'(state), 1);
      step();
      check("wide_state", 32'(state),    2);
      check("wide_lock",  32'(lock),     1);
      check("wide_gain",  32'(gain_sel), 1);

      // one more pass -> TRACK_NARROW
      epochs(20, 16'sd1000, 16'sd100);
      step(); step();
      check("narrow_state", 32'(state),    3);
      check("narrow_gain",  32'(gain_sel), 2);
      check("narrow_lock",  32'(lock),     1);

      // two failing windows; epoch 42 lands on the clear cycle
      epochs(42, 16'sd100, 16'sd1000);
      check("lost_state",     32'(state),       1);
      check("lost_clear",     32'(filt_clear),  1);
      check("clear_wins_upd", 32'(filt_update), 0);
      check("lost_lock",      32'(lock),        0);
      check("lost_gain",      32'(gain_sel),    0);
      step();
      check("lost_clear_pulse", 32'(filt_clear), 0);

      enable = 1'b0; step();
      check("disable_idle", 32'(state), 0);
      enable = 1'b1; step();
      check("reenable_pullin", 32'(state), 1);

      // w1: 16 saturated hits pass
      epochs(16, -16'sd32768, 16'sd0); epochs(4, 16'sd50, 16'sd0);
      step(); step();
      check("w1_pullin", 32'(state), 1);
      // w2: 15 hits, 50/0 and 200/100 are not hits
      epochs(15, 16'sd1000, 16'sd100); epochs(3, 16'sd50, 16'sd0); epochs(2, 16'sd200, 16'sd100);
      step(); step();
      check("hit15_fails", 32'(state), 1);
      epochs(16, -16'sd32768, 16'sd0); epochs(4, 16'sd50, 16'sd0);
      step(); step();
      check("w3_pullin", 32'(state), 1);
      epochs(16, 16'sd1000, 16'sd100); epochs(4, 16'sd50, 16'sd0);
      step(); step();
      check("hit16_to_wide", 32'(state), 2);

      // enable drop mid-window in TRACK_WIDE
      epochs(5, 16'sd1000, 16'sd100);
      enable = 1'b0; step();
      check("drop_state", 32'(state),    0);
      check("drop_lock",  32'(lock),     0);
      check("drop_gain",  32'(gain_sel), 0);
      enable = 1'b1; step();
      check("fresh_pullin", 32'(state),      1);
      check("fresh_clear",  32'(filt_clear), 1);
      epochs(40, 16'sd1000, 16'sd100);
      step();
      check("fresh_counters", 32'(state), 1);
      step();
      check("fresh_wide", 32'(state), 2);

      // 50 noisy windows -> pull-in timeout
      enable = 1'b0; step();
      enable = 1'b1; step();
      check("noise_pullin", 32'(state), 1);
      to_base = to_seen;
      epochs(1000, 16'sd500, 16'sd500);
      step();
      check("no_early_timeout", 32'(to_seen - to_base), 0);
      check("timeout_not_yet",  32'(pull_timeout),      0);
      step();
      check("timeout_pulse", 32'(pull_timeout), 1);
      check("timeout_clear", 32'(filt_clear),   1);
      check("timeout_state", 32'(state),        1);
      check("timeout_lock",  32'(lock),         0);
      step();
      check("timeout_one_cycle", 32'(pull_timeout), 0);
      check("timeout_clear_end", 32'(filt_clear),   0);
      check("timeout_stay",      32'(state),        1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
